// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// mult/multu use shift-add, div/divu use restoring division; each takes WIDTH
// iterations plus one sign-fix cycle. mthi/mtlo write HI/LO directly from IDLE.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [5:0] OP_MULT  = 6'd24;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_DIV   = 6'd26;
    localparam logic [5:0] OP_DIVU  = 6'd27;
    localparam logic [5:0] OP_MTHI  = 6'd17;
    localparam logic [5:0] OP_MTLO  = 6'd19;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     acc;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]  opb;       // multiplicand or divisor magnitude
    logic              is_mul_q;
    logic              neg_q_q;   // negate product / quotient
    logic              neg_r_q;   // negate remainder
    logic              div0_q;

    logic              is_mul_op_c;
    logic              is_div_op_c;
    logic              is_signed_c;
    logic [WIDTH-1:0]  mag_a_c;
    logic [WIDTH-1:0]  mag_b_c;

    logic              load_c;
    logic              mthi_c;
    logic              mtlo_c;
    logic              step_c;
    logic              fix_c;
    logic              abort_c;

    logic [WIDTH:0]    mul_sum_c;
    logic [PW-1:0]     mul_next_c;
    logic [WIDTH:0]    div_trial_c;
    logic [WIDTH:0]    div_diff_c;
    logic              div_ge_c;
    logic [PW-1:0]     div_next_c;
    logic [PW-1:0]     prod_fix_c;
    logic [WIDTH-1:0]  quo_fix_c;
    logic [WIDTH-1:0]  rem_fix_c;

    // Opcode decode and operand magnitudes for signed ops
    always_comb begin
        is_mul_op_c = (op == OP_MULT) || (op == OP_MULTU);
        is_div_op_c = (op == OP_DIV)  || (op == OP_DIVU);
        is_signed_c = (op == OP_MULT) || (op == OP_DIV);
        mag_a_c     = (is_signed_c && src_a[WIDTH-1]) ? WIDTH'(0) - src_a : src_a;
        mag_b_c     = (is_signed_c && src_b[WIDTH-1]) ? WIDTH'(0) - src_b : src_b;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush aborts any non-idle state and suppresses a start in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    if (is_mul_op_c) begin
                        state_nxt = S_MUL;
                    end else if (is_div_op_c) begin
                        state_nxt = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CW'(1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Control strobes derived from state and request
    always_comb begin
        load_c  = 1'b0;
        mthi_c  = 1'b0;
        mtlo_c  = 1'b0;
        step_c  = 1'b0;
        fix_c   = 1'b0;
        abort_c = 1'b0;
        case (state)
            S_IDLE: begin
                load_c = start && !flush && (is_mul_op_c || is_div_op_c);
                mthi_c = start && !flush && (op == OP_MTHI);
                mtlo_c = start && !flush && (op == OP_MTLO);
            end
            S_MUL, S_DIV: begin
                step_c  = !flush;
                abort_c = flush;
            end
            S_FIX: begin
                fix_c   = !flush;
                abort_c = flush;
            end
            default: begin
                abort_c = 1'b1;
            end
        endcase
    end

    // One shift-add step, one restoring-division step, and the final sign fix
    always_comb begin
        mul_sum_c   = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, opb} : (WIDTH+1)'(0));
        mul_next_c  = {mul_sum_c, acc[WIDTH-1:1]};

        div_trial_c = {acc[PW-1:WIDTH], acc[WIDTH-1]};
        div_diff_c  = div_trial_c - {1'b0, opb};
        div_ge_c    = (div_trial_c >= {1'b0, opb});
        div_next_c  = {(div_ge_c ? div_diff_c[WIDTH-1:0] : div_trial_c[WIDTH-1:0]),
                       acc[WIDTH-2:0], div_ge_c};

        prod_fix_c  = neg_q_q ? PW'(0) - acc : acc;
        quo_fix_c   = div0_q ? {WIDTH{1'b1}}
                    : (neg_q_q ? WIDTH'(0) - acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        rem_fix_c   = neg_r_q ? WIDTH'(0) - acc[PW-1:WIDTH] : acc[PW-1:WIDTH];
    end

    // Datapath, HI/LO and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            is_mul_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            if (load_c) begin
                cnt      <= CW'(WIDTH);
                acc      <= {WIDTH'(0), mag_a_c};
                opb      <= mag_b_c;
                is_mul_q <= is_mul_op_c;
                neg_q_q  <= is_signed_c && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_r_q  <= is_signed_c && src_a[WIDTH-1];
                div0_q   <= is_div_op_c && (src_b == WIDTH'(0));
                busy     <= 1'b1;
            end
            if (mthi_c) begin
                hi   <= src_a;
                done <= 1'b1;
            end
            if (mtlo_c) begin
                lo   <= src_a;
                done <= 1'b1;
            end
            if (step_c) begin
                acc <= (state == S_MUL) ? mul_next_c : div_next_c;
                cnt <= cnt - CW'(1);
            end
            if (fix_c) begin
                if (is_mul_q) begin
                    hi <= prod_fix_c[PW-1:WIDTH];
                    lo <= prod_fix_c[WIDTH-1:0];
                end else begin
                    hi <= rem_fix_c;
                    lo <= quo_fix_c;
                end
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (abort_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected HI/LO into a
// scoreboard queue, a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [5:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (hi=%h lo=%h)", hi, lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_hi"}, hi, e.hi);
                chk({e.name, "_lo"}, lo, e.lo);
            end
        end
    end

    task automatic launch(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input bit push,
                          input string name);
        exp_t e;
        if (push) begin
            e.hi = eh;
            e.lo = el;
            e.name = name;
            sb.push_back(e);
            m_hi = eh;
            m_lo = el;
        end
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
    endtask

    task automatic wait_done(output int k, output int nbusy);
        nbusy = 0;
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            op    = 6'd0;
            src_a = 32'hA5A5_A5A5;
            src_b = 32'h5A5A_5A5A;
            if (busy) nbusy++;
            if (done) begin
                k = i;
                break;
            end
        end
        if (k == 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done within 60 cycles expected done");
        end
    endtask

    task automatic run(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input string name);
        int k;
        int nb;
        int exp_k;
        int exp_b;
        launch(o, a, b, eh, el, 1'b1, name);
        wait_done(k, nb);
        exp_k = (o == 6'd17 || o == 6'd19) ? 1 : W + 2;
        exp_b = (o == 6'd17 || o == 6'd19) ? 0 : W + 1;
        chk({name, "_latency"}, W'(k), W'(exp_k));
        chk({name, "_busy_cycles"}, W'(nb), W'(exp_b));
        @(negedge clk);
        chk({name, "_done_pulse"}, W'(done), W'(0));
    endtask

    initial begin
        int k;
        int nb;
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        src_a = '0;
        src_b = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);

        run(6'd17, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'h0000_0000, "mthi");
        run(6'd19, 32'h0000_5678, 32'h0, 32'h0000_1234, 32'h0000_5678, "mtlo");
        run(6'd24, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
        run(6'd25, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
        run(6'd24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1m1");
        run(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run(6'd26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        run(6'd26, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2");
        run(6'd27, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, "divu_by0");
        run(6'd26, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0");
        run(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
        run(6'd27, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, "divu_100_7");

        // flush and start together in IDLE: start dropped
        start = 1'b1; op = 6'd17; src_a = 32'hDEAD_0000; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_hi", hi, m_hi);
        chk("idle_flush_busy", W'(busy), W'(0));

        // mthi issued while a mult is busy is ignored
        launch(6'd24, 32'd5, 32'd7, 32'h0, 32'd35, 1'b0, "");
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 6'd17; src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_mthi_hi", hi, m_hi);
        launch(6'd0, 32'h0, 32'h0, 32'h0, 32'd35, 1'b1, "mult_after_mthi");
        start = 1'b0;
        wait_done(k, nb);
        @(negedge clk);

        // flush in the middle of a div: no done, HI/LO untouched
        launch(6'd27, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0, "");
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", W'(busy), W'(0));
        repeat (40) @(negedge clk);
        chk("flush_hi", hi, m_hi);
        chk("flush_lo", lo, m_lo);

        // asynchronous reset in the middle of a mult
        launch(6'd25, 32'd123, 32'd456, 32'h0, 32'h0, 1'b0, "");
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        chk("arst_busy", W'(busy), W'(0));
        chk("arst_done", W'(done), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        run(6'd26, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, "div_after_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", W'(sb.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
